// File: rtl/ex_alu_unit.sv
// ex_alu_unit: execute-stage compute block for a 5-stage RV32I pipeline.
// Decodes ALU control from alu_op/funct3/funct7, runs the 32-bit ALU,
// adds PC+imm for the branch target and resolves the branch condition.
// All outputs are registered (1-cycle latency) and feed the MEM stage.
// Optional feature: define ALU_MUL_EN to decode funct7=0000001 R-type as MUL.
module ex_alu_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [1:0]      alu_op_i,
    input  logic            branch_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic [XLEN-1:0] branch_addr_o,
    output logic            branch_taken_o,
    output logic [3:0]      alu_ctrl_o
);

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_XOR  = 4'b0011;
    localparam logic [3:0] CTRL_SLL  = 4'b0100;
    localparam logic [3:0] CTRL_SRL  = 4'b0101;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_SRA  = 4'b1000;
    localparam logic [3:0] CTRL_SLTU = 4'b1001;
    localparam logic [3:0] CTRL_MUL  = 4'b1010;

    localparam logic [6:0] F7_ALT = 7'b0100000;
    localparam logic [6:0] F7_MUL = 7'b0000001;

    logic [3:0]             ctrl_d;
    logic [XLEN-1:0]        result_d;
    logic                   zero_d;
    logic                   taken_d;
    logic [XLEN-1:0]        addr_d;
    logic signed [XLEN-1:0] op_a_s;
    logic signed [XLEN-1:0] op_b_s;
    logic [4:0]             shamt;
    logic                   f7_alt;

    logic                   valid_q;
    logic [XLEN-1:0]        result_q;
    logic                   zero_q;
    logic                   taken_q;
    logic [XLEN-1:0]        addr_q;
    logic [3:0]             ctrl_q;

    assign op_a_s = op_a_i;
    assign op_b_s = op_b_i;
    assign shamt  = op_b_i[4:0];
    // Unlisted funct7 values fall back to the 0000000 decode.
    assign f7_alt = (funct7_i == F7_ALT);

    // ALU control decode from alu_op, funct3 and funct7.
    always_comb begin
        ctrl_d = CTRL_ADD;
        unique case (alu_op_i)
            2'b00: ctrl_d = CTRL_ADD;
            2'b01: begin
                unique case (funct3_i)
                    3'b100, 3'b101: ctrl_d = CTRL_SLT;
                    3'b110, 3'b111: ctrl_d = CTRL_SLTU;
                    default:        ctrl_d = CTRL_SUB;
                endcase
            end
            default: begin
                unique case (funct3_i)
                    // ADDI never subtracts, so funct7 matters only for R-type here.
                    3'b000:  ctrl_d = (alu_op_i == 2'b10 && f7_alt) ? CTRL_SUB : CTRL_ADD;
                    3'b001:  ctrl_d = CTRL_SLL;
                    3'b010:  ctrl_d = CTRL_SLT;
                    3'b011:  ctrl_d = CTRL_SLTU;
                    3'b100:  ctrl_d = CTRL_XOR;
                    3'b101:  ctrl_d = f7_alt ? CTRL_SRA : CTRL_SRL;
                    3'b110:  ctrl_d = CTRL_OR;
                    default: ctrl_d = CTRL_AND;
                endcase
`ifdef ALU_MUL_EN
                if (alu_op_i == 2'b10 && funct7_i == F7_MUL) begin
                    ctrl_d = CTRL_MUL;
                end
`endif
            end
        endcase
    end

    // ALU datapath; all arithmetic wraps modulo 2^XLEN.
    always_comb begin
        result_d = '0;
        unique case (ctrl_d)
            CTRL_AND:  result_d = op_a_i & op_b_i;
            CTRL_OR:   result_d = op_a_i | op_b_i;
            CTRL_ADD:  result_d = op_a_i + op_b_i;
            CTRL_XOR:  result_d = op_a_i ^ op_b_i;
            CTRL_SLL:  result_d = op_a_i << shamt;
            CTRL_SRL:  result_d = op_a_i >> shamt;
            CTRL_SUB:  result_d = op_a_i - op_b_i;
            CTRL_SLT:  result_d = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
            CTRL_SRA:  result_d = op_a_s >>> shamt;
            CTRL_SLTU: result_d = {{(XLEN-1){1'b0}}, (op_a_i < op_b_i)};
`ifdef ALU_MUL_EN
            // Only funct3=000 (MUL) is implemented; other M-ops return 0.
            CTRL_MUL:  result_d = (funct3_i == 3'b000) ? (op_a_i * op_b_i) : '0;
`endif
            default:   result_d = '0;
        endcase
    end

    // Branch condition resolution and branch target.
    always_comb begin
        zero_d  = (result_d == '0);
        addr_d  = pc_i + imm_i;
        taken_d = 1'b0;
        unique case (funct3_i)
            3'b000:         taken_d = zero_d;
            3'b001:         taken_d = !zero_d;
            3'b100, 3'b110: taken_d = result_d[0];
            3'b101, 3'b111: taken_d = !result_d[0];
            default:        taken_d = 1'b0;
        endcase
        taken_d = taken_d & branch_i;
    end

    // Output register: data holds when no valid instruction, valid always tracks valid_i.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            taken_q  <= 1'b0;
            addr_q   <= '0;
            ctrl_q   <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                result_q <= result_d;
                zero_q   <= zero_d;
                taken_q  <= taken_d;
                addr_q   <= addr_d;
                ctrl_q   <= ctrl_d;
            end
        end
    end

    assign valid_o        = valid_q;
    assign result_o       = result_q;
    assign zero_o         = zero_q;
    assign branch_addr_o  = addr_q;
    assign branch_taken_o = taken_q;
    assign alu_ctrl_o     = ctrl_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed testbench for ex_alu_unit with hand-computed expected values.
module tb_ex_alu_unit;

    logic        clk;
    logic        reset;
    logic        valid_i;
    logic [1:0]  alu_op_i;
    logic        branch_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic [31:0] pc_i;
    logic [31:0] imm_i;
    logic        valid_o;
    logic [31:0] result_o;
    logic        zero_o;
    logic [31:0] branch_addr_o;
    logic        branch_taken_o;
    logic [3:0]  alu_ctrl_o;

    int errors = 0;
    int checks = 0;

    ex_alu_unit #(.XLEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_i        (valid_i),
        .alu_op_i       (alu_op_i),
        .branch_i       (branch_i),
        .funct3_i       (funct3_i),
        .funct7_i       (funct7_i),
        .op_a_i         (op_a_i),
        .op_b_i         (op_b_i),
        .pc_i           (pc_i),
        .imm_i          (imm_i),
        .valid_o        (valid_o),
        .result_o       (result_o),
        .zero_o         (zero_o),
        .branch_addr_o  (branch_addr_o),
        .branch_taken_o (branch_taken_o),
        .alu_ctrl_o     (alu_ctrl_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic vld, input logic [31:0] res,
                           input logic zero, input logic [31:0] addr, input logic taken,
                           input logic [3:0] ctrl);
        chk({tag, ".valid"}, {31'b0, valid_o}, {31'b0, vld});
        chk({tag, ".result"}, result_o, res);
        chk({tag, ".zero"}, {31'b0, zero_o}, {31'b0, zero});
        chk({tag, ".addr"}, branch_addr_o, addr);
        chk({tag, ".taken"}, {31'b0, branch_taken_o}, {31'b0, taken});
        chk({tag, ".ctrl"}, {28'b0, alu_ctrl_o}, {28'b0, ctrl});
    endtask

    task automatic drive(input logic [1:0] op, input logic br, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm);
        valid_i  = 1'b1;
        alu_op_i = op;
        branch_i = br;
        funct3_i = f3;
        funct7_i = f7;
        op_a_i   = a;
        op_b_i   = b;
        pc_i     = pc;
        imm_i    = imm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(2'b00, 1'b0, 3'b000, 7'h00, 32'd0, 32'd0, 32'd0, 32'd0);
        valid_i = 1'b0;
        #12;
        chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0);
        reset = 1'b0;

        // R-type SUB: 5-7
        drive(2'b10, 1'b0, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'h0, 32'h0);
        step();
        chk_all("sub", 1'b1, 32'hFFFFFFFE, 1'b0, 32'h0, 1'b0, 4'b0110);

        // I-type SRA / SRL
        drive(2'b11, 1'b0, 3'b101, 7'b0100000, 32'h80000000, 32'd4, 32'h0, 32'h0);
        step();
        chk("srai.result", result_o, 32'hF8000000);
        chk("srai.ctrl", {28'b0, alu_ctrl_o}, 32'h8);
        drive(2'b11, 1'b0, 3'b101, 7'b0000000, 32'h80000000, 32'd4, 32'h0, 32'h0);
        step();
        chk("srli.result", result_o, 32'h08000000);
        chk("srli.ctrl", {28'b0, alu_ctrl_o}, 32'h5);

        // ADDI ignores funct7 even when it looks like SUB
        drive(2'b11, 1'b0, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'h0, 32'h0);
        step();
        chk("addi.result", result_o, 32'd12);
        chk("addi.ctrl", {28'b0, alu_ctrl_o}, 32'h2);

        // Load/store add ignores funct fields
        drive(2'b00, 1'b0, 3'b111, 7'b0100000, 32'd10, 32'd20, 32'h0, 32'h0);
        step();
        chk("ls.result", result_o, 32'd30);
        chk("ls.ctrl", {28'b0, alu_ctrl_o}, 32'h2);

        // R-type logic/shift/compare
        drive(2'b10, 1'b0, 3'b001, 7'h00, 32'd1, 32'h25, 32'h0, 32'h0);
        step();
        chk("sll.result", result_o, 32'h20);
        chk("sll.ctrl", {28'b0, alu_ctrl_o}, 32'h4);
        drive(2'b10, 1'b0, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
        step();
        chk("slt.result", result_o, 32'd1);
        drive(2'b10, 1'b0, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
        step();
        chk("sltu.result", result_o, 32'd0);
        chk("sltu.zero", {31'b0, zero_o}, 32'd1);
        drive(2'b10, 1'b0, 3'b100, 7'h00, 32'h0000F0F0, 32'h0000FF00, 32'h0, 32'h0);
        step();
        chk("xor.result", result_o, 32'h00000FF0);
        drive(2'b10, 1'b0, 3'b110, 7'h00, 32'h0000F0F0, 32'h0000FF00, 32'h0, 32'h0);
        step();
        chk("or.result", result_o, 32'h0000FFF0);
        drive(2'b10, 1'b0, 3'b111, 7'h00, 32'h0000F0F0, 32'h0000FF00, 32'h0, 32'h0);
        step();
        chk("and.result", result_o, 32'h0000F000);
        chk("and.ctrl", {28'b0, alu_ctrl_o}, 32'h0);
        // Unlisted funct7 decodes as 0000000
        drive(2'b10, 1'b0, 3'b000, 7'b0000010, 32'd3, 32'd4, 32'h0, 32'h0);
        step();
        chk("f7dflt.result", result_o, 32'd7);

        // Branches: BLT / BLTU / BGE / BNE
        drive(2'b01, 1'b1, 3'b100, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
        step();
        chk("blt.taken", {31'b0, branch_taken_o}, 32'd1);
        chk("blt.ctrl", {28'b0, alu_ctrl_o}, 32'h7);
        drive(2'b01, 1'b1, 3'b110, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
        step();
        chk("bltu.taken", {31'b0, branch_taken_o}, 32'd0);
        chk("bltu.ctrl", {28'b0, alu_ctrl_o}, 32'h9);
        drive(2'b01, 1'b1, 3'b101, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
        step();
        chk("bge.taken", {31'b0, branch_taken_o}, 32'd0);
        drive(2'b01, 1'b1, 3'b111, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
        step();
        chk("bgeu.taken", {31'b0, branch_taken_o}, 32'd1);
        drive(2'b01, 1'b1, 3'b001, 7'h00, 32'd3, 32'd3, 32'h0, 32'h0);
        step();
        chk("bne.taken", {31'b0, branch_taken_o}, 32'd0);
        drive(2'b01, 1'b1, 3'b010, 7'h00, 32'd3, 32'd3, 32'h0, 32'h0);
        step();
        chk("b010.taken", {31'b0, branch_taken_o}, 32'd0);
        drive(2'b01, 1'b0, 3'b000, 7'h00, 32'd3, 32'd3, 32'h0, 32'h0);
        step();
        chk("nobr.taken", {31'b0, branch_taken_o}, 32'd0);

        // BEQ with negative offset, then a bubble: data holds, valid drops
        drive(2'b01, 1'b1, 3'b000, 7'h00, 32'd9, 32'd9, 32'h100, 32'hFFFFFFF0);
        step();
        chk_all("beq", 1'b1, 32'h0, 1'b1, 32'h000000F0, 1'b1, 4'b0110);
        drive(2'b10, 1'b0, 3'b000, 7'h00, 32'd1, 32'd2, 32'h0, 32'h0);
        valid_i = 1'b0;
        step();
        chk_all("hold", 1'b0, 32'h0, 1'b1, 32'h000000F0, 1'b1, 4'b0110);

        // Branch target wraps
        drive(2'b00, 1'b0, 3'b000, 7'h00, 32'd0, 32'd0, 32'hFFFFFFFC, 32'd8);
        step();
        chk("wrap.addr", branch_addr_o, 32'h4);

        // MUL option
        drive(2'b10, 1'b0, 3'b000, 7'b0000001, 32'h00010000, 32'h00010001, 32'h0, 32'h0);
        step();
`ifdef ALU_MUL_EN
        chk("mul.result", result_o, 32'h00010000);
        chk("mul.ctrl", {28'b0, alu_ctrl_o}, 32'hA);
        drive(2'b10, 1'b0, 3'b001, 7'b0000001, 32'd3, 32'd4, 32'h0, 32'h0);
        step();
        chk("mulh.result", result_o, 32'h0);
        chk("mulh.ctrl", {28'b0, alu_ctrl_o}, 32'hA);
`else
        chk("mul.result", result_o, 32'h00020001);
        chk("mul.ctrl", {28'b0, alu_ctrl_o}, 32'h2);
`endif

        // Asynchronous reset mid-run with valid_i held high
        drive(2'b10, 1'b0, 3'b000, 7'h00, 32'd1, 32'd1, 32'h10, 32'h4);
        step();
        chk("pre_rst.result", result_o, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0);
        step();
        chk("rst_hold.valid", {31'b0, valid_o}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_rel.valid", {31'b0, valid_o}, 32'd0);
        step();
        chk_all("post_rst", 1'b1, 32'd2, 1'b0, 32'h14, 1'b0, 4'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
